// File: rtl/inv_key_schedule.sv
// S-AES round-key sequencer: streams K2, K1, K0 for the inverse rounds.
// Define KEY_FWD_MODE_EN to also accept K0 and expand forward.
module inv_key_schedule (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Mode,
  input  logic [15:0] Key_In,
  input  logic        Key_Ready,
  output logic        Key_Valid,
  output logic [15:0] Key_Out,
  output logic [1:0]  Round_Idx,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {
    IDLE,
    C1,
    C2,
    STREAM,
    FIN
  } state_t;

  localparam logic [7:0] RC1 = 8'h80;
  localparam logic [7:0] RC2 = 8'h30;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] r0;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [1:0]  idx;
  logic        fwd;
  logic [15:0] src;
  logic [7:0]  g_in;
  logic [7:0]  g_rc;
  logic [7:0]  g_out;
  logic [15:0] step_key;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    logic [3:0] s;
    unique case (n)
      4'h0: s = 4'h9;
      4'h1: s = 4'h4;
      4'h2: s = 4'hA;
      4'h3: s = 4'hB;
      4'h4: s = 4'hD;
      4'h5: s = 4'h1;
      4'h6: s = 4'h8;
      4'h7: s = 4'h5;
      4'h8: s = 4'h6;
      4'h9: s = 4'h2;
      4'hA: s = 4'h0;
      4'hB: s = 4'h3;
      4'hC: s = 4'hC;
      4'hD: s = 4'hE;
      4'hE: s = 4'hF;
      default: s = 4'h7;
    endcase
    return s;
  endfunction

`ifdef KEY_FWD_MODE_EN
  logic mode_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q <= 1'b0;
    end else if (state == IDLE && Start) begin
      mode_q <= Mode;
    end
  end

  assign fwd = ~mode_q;
`else
  logic unused_mode;

  assign unused_mode = Mode;
  assign fwd = 1'b0;
`endif

  // Source word for the current compute cycle.
  always_comb begin
    src = 16'h0000;
    unique case (state)
      C1:      src = fwd ? r0 : r2;
      C2:      src = r1;
      default: src = 16'h0000;
    endcase
  end

  // One shared g-function: forward feeds w(odd), inverse feeds hi^lo.
  always_comb begin
    g_in = 8'h00;
    g_rc = 8'h00;
    unique case (state)
      C1: begin
        g_in = fwd ? src[7:0] : (src[15:8] ^ src[7:0]);
        g_rc = fwd ? RC1 : RC2;
      end
      C2: begin
        g_in = fwd ? src[7:0] : (src[15:8] ^ src[7:0]);
        g_rc = fwd ? RC2 : RC1;
      end
      default: begin
        g_in = 8'h00;
        g_rc = 8'h00;
      end
    endcase
  end

  assign g_out = {sbox(g_in[3:0]), sbox(g_in[7:4])} ^ g_rc;

  // High word is hi^g in both directions; low word differs.
`ifdef KEY_FWD_MODE_EN
  assign step_key = fwd
    ? {src[15:8] ^ g_out, src[15:8] ^ g_out ^ src[7:0]}
    : {src[15:8] ^ g_out, src[15:8] ^ src[7:0]};
`else
  assign step_key = {src[15:8] ^ g_out, src[15:8] ^ src[7:0]};
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = C1;
      C1:      state_nxt = C2;
      C2:      state_nxt = STREAM;
      STREAM:  if (Key_Ready && idx == 2'd0) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r0  <= 16'h0000;
      r1  <= 16'h0000;
      r2  <= 16'h0000;
      idx <= 2'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            if (fwd_cap(Mode)) r0 <= Key_In;
            else               r2 <= Key_In;
          end
        end
        C1: r1 <= step_key;
        C2: begin
          if (fwd) r2 <= step_key;
          else     r0 <= step_key;
          idx <= 2'd2;
        end
        STREAM: begin
          if (Key_Ready && idx != 2'd0) idx <= idx - 2'd1;
        end
        default: ;
      endcase
    end
  end

  function automatic logic fwd_cap(input logic m);
`ifdef KEY_FWD_MODE_EN
    return ~m;
`else
    logic unused_m;
    unused_m = m;
    return 1'b0;
`endif
  endfunction

  always_comb begin
    Key_Valid = 1'b0;
    Key_Out   = 16'h0000;
    Busy      = 1'b0;
    Done      = 1'b0;
    unique case (state)
      C1, C2: Busy = 1'b1;
      STREAM: begin
        Busy      = 1'b1;
        Key_Valid = 1'b1;
        unique case (idx)
          2'd2:    Key_Out = r2;
          2'd1:    Key_Out = r1;
          default: Key_Out = r0;
        endcase
      end
      FIN:     Done = 1'b1;
      default: ;
    endcase
  end

  assign Round_Idx = idx;

endmodule
